// File: rtl/mux_sel_arbiter_16.sv
// Round-robin owner of the shared 16-input bus mux: picks one requester,
// drives the mux select lines with its index and returns a one-hot grant.
// Tenure is capped at MAX_HOLD cycles only while someone else is waiting.
module mux_sel_arbiter_16 #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic        sel3,
    output logic        sel2,
    output logic        sel1,
    output logic        sel0,
    output logic        bus_valid
);

    typedef enum logic {
        StIdle,
        StGrant
    } state_t;

    localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(MAX_HOLD - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_owner;
    logic [3:0]        w_owner_nxt;
    logic [3:0]        r_ptr;
    logic [3:0]        w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [15:0]       r_gnt;
    logic [15:0]       w_gnt_nxt;

    logic [15:0]       w_owner_oh;
    logic              w_others;
    logic [3:0]        w_ptr_after;
    logic [3:0]        w_pick_idle;
    logic [3:0]        w_pick_rot;

    // First set bit of vec scanning start, start+1, ... with wrap at 16.
    function automatic logic [3:0] f_pick(input logic [15:0] vec, input logic [3:0] start);
        logic [3:0] v_idx;
        logic [3:0] v_win;
        logic       v_found;
        v_win   = start;
        v_found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            v_idx = start + 4'(k);
            if (!v_found && vec[v_idx]) begin
                v_win   = v_idx;
                v_found = 1'b1;
            end
        end
        return v_win;
    endfunction

    // Candidate winners: from ptr when idle, from owner+1 (owner masked) when handing over.
    always_comb begin
        w_owner_oh  = 16'h0001 << r_owner;
        w_others    = |(req & ~w_owner_oh);
        w_ptr_after = r_owner + 4'd1;
        w_pick_idle = f_pick(req, r_ptr);
        w_pick_rot  = f_pick(req & ~w_owner_oh, w_ptr_after);
    end

    // Next-state: grant, release, forced rotation and tenure counting.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            StIdle: begin
                if (|req) begin
                    w_state_nxt = StGrant;
                    w_owner_nxt = w_pick_idle;
                    w_gnt_nxt   = 16'h0001 << w_pick_idle;
                    w_hold_nxt  = '0;
                end
            end
            StGrant: begin
                if (!req[r_owner]) begin
                    // Release: hand over on the same edge if anyone waits.
                    w_ptr_nxt  = w_ptr_after;
                    w_hold_nxt = '0;
                    if (w_others) begin
                        w_owner_nxt = w_pick_rot;
                        w_gnt_nxt   = 16'h0001 << w_pick_rot;
                    end else begin
                        // sel keeps the last owner; bus_valid qualifies it.
                        w_state_nxt = StIdle;
                        w_gnt_nxt   = '0;
                    end
                end else if (r_hold == HoldLast) begin
                    w_hold_nxt = '0;
                    if (w_others) begin
                        w_ptr_nxt   = w_ptr_after;
                        w_owner_nxt = w_pick_rot;
                        w_gnt_nxt   = 16'h0001 << w_pick_rot;
                    end
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State registers; reset aborts any tenure immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        gnt                    = r_gnt;
        {sel3, sel2, sel1, sel0} = r_owner;
        bus_valid              = (r_state == StGrant);
    end

endmodule

// File: tb/tb_mux_sel_arbiter_16.sv
module tb_mux_sel_arbiter_16;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] gnt;
    logic        sel3;
    logic        sel2;
    logic        sel1;
    logic        sel0;
    logic        bus_valid;
    logic [3:0]  sel;

    int n_cmp;
    int n_err;

    assign sel = {sel3, sel2, sel1, sel0};

    mux_sel_arbiter_16 #(
        .MAX_HOLD(4),
        .HOLD_W  (3)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .sel3     (sel3),
        .sel2     (sel2),
        .sel1     (sel1),
        .sel0     (sel0),
        .bus_valid(bus_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle; inputs driven here reach the next edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus(input string tag, input logic [15:0] e_gnt, input logic [3:0] e_sel,
                             input logic e_bv);
        check_eq({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
        check_eq({tag, ".sel"}, 32'(sel), 32'(e_sel));
        check_eq({tag, ".bv"}, 32'(bus_valid), 32'(e_bv));
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        req   = '0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = '0;

        // 1a: reset held with clock running
        repeat (3) tick();
        check_bus("rst_hold", 16'h0000, 4'd0, 1'b0);
        rst_n = 1'b1;

        // 2: single requester 5 for three cycles, ptr ends at 6
        req = 16'h0020;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bus("single5", 16'h0020, 4'd5, 1'b1);
        end
        req = '0;
        tick();
        check_bus("single5_rel", 16'h0000, 4'd5, 1'b0);

        // 1b: from ptr=6, req {8,0} picks 8; async reset mid-grant; restart from ptr=0
        req = 16'h0101;
        tick();
        check_bus("ptr6_pick8", 16'h0100, 4'd8, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_bus("async_rst", 16'h0000, 4'd0, 1'b0);
        rst_n = 1'b1;
        tick();
        check_bus("rst_ptr0", 16'h0001, 4'd0, 1'b1);
        req = '0;
        tick();

        // 3: all requesting, four cycles each, full wrap
        do_reset();
        req = 16'hFFFF;
        for (int c = 0; c < 68; c++) begin
            int o;
            o = (c / 4) % 16;
            tick();
            check_bus("rr_all", 16'h0001 << o, 4'(o), 1'b1);
        end
        req = '0;
        tick();
        check_eq("rr_all_idle", 32'(bus_valid), 32'd0);

        // 4: owner 3 releases (ptr=4), then req {9,3}
        do_reset();
        req = 16'h0008;
        tick();
        check_bus("own3", 16'h0008, 4'd3, 1'b1);
        req = '0;
        tick();
        check_bus("own3_rel", 16'h0000, 4'd3, 1'b0);
        req = 16'h0208;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_bus("ptr4_pick9", 16'h0200, 4'd9, 1'b1);
        end
        tick();
        check_bus("rot_to3", 16'h0008, 4'd3, 1'b1);
        req = '0;
        tick();

        // 5: uncontended 7 keeps bus; 2 arrives mid-window and waits for the window end
        do_reset();
        req = 16'h0080;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c < 8) check_bus("hold7", 16'h0080, 4'd7, 1'b1);
            else       check_bus("forced2", 16'h0004, 4'd2, 1'b1);
            if (c == 5) req = 16'h0084;
        end
        req = '0;
        tick();
        check_bus("forced2_rel", 16'h0000, 4'd2, 1'b0);

        // 6: owner 14 drops as 1 rises; search wraps 15 -> 0 -> 1
        do_reset();
        req = 16'h4000;
        tick();
        check_bus("own14", 16'h4000, 4'd14, 1'b1);
        req = 16'h0002;
        tick();
        check_bus("wrap1", 16'h0002, 4'd1, 1'b1);
        req = '0;
        tick();
        check_bus("wrap1_rel", 16'h0000, 4'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
